inter_core_fifo: RTL and testbench

- Mailbox FIFO that links neighbouring cores in the cluster ring.
- The upstream core's FIFO master port pushes 32-bit words over a peripheral-bus-style request/grant/response handshake.
- The downstream core's FIFO slave port pops words and reads status over the same handshake.
- One instance sits between each pair of adjacent core regions.

---
 rtl/inter_core_fifo.sv | 132 +++++++++++++
 tb/tb_inter_core_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/inter_core_fifo.sv
// Mailbox FIFO between adjacent core regions: the upstream core pushes words and the downstream core pops them.
// Both ports use a request/grant handshake with a registered one-cycle response.
module inter_core_fifo #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 5,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_req_i,
    input  logic                  push_wen_i,
    input  logic [DATA_WIDTH-1:0] push_wdata_i,
    input  logic [ID_WIDTH-1:0]   push_id_i,
    output logic                  push_gnt_o,
    output logic                  push_r_valid_o,
    output logic                  push_r_opc_o,
    output logic [ID_WIDTH-1:0]   push_r_id_o,
    input  logic                  pop_req_i,
    input  logic [3:0]            pop_add_i,
    input  logic                  pop_wen_i,
    input  logic [ID_WIDTH-1:0]   pop_id_i,
    output logic                  pop_gnt_o,
    output logic                  pop_r_valid_o,
    output logic                  pop_r_opc_o,
    output logic [ID_WIDTH-1:0]   pop_r_id_o,
    output logic [DATA_WIDTH-1:0] pop_r_rdata_o,
    output logic                  nonempty_o
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_next;

    logic                  is_data;
    logic                  is_status;
    logic                  push_write;
    logic                  pop_data;
    logic                  pop_cond;
    logic [DATA_WIDTH-1:0] status_word;
    logic [DATA_WIDTH-1:0] pop_rdata_next;
    logic                  pop_opc_next;

    assign is_data   = (pop_add_i == 4'h0);
    assign is_status = (pop_add_i == 4'h4);

    // Grants look only at the pre-update count, so a full FIFO never accepts
    // a push in the same cycle as a pop and a word cannot fall through.
    assign push_gnt_o = push_req_i & (push_wen_i | (count != FULL_CNT));
    assign pop_cond   = ~pop_wen_i | ~is_data | (count != '0);
    assign pop_gnt_o  = pop_req_i & pop_cond;

    assign push_write = push_gnt_o & ~push_wen_i;
    assign pop_data   = pop_gnt_o & pop_wen_i & is_data;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        status_word                   = '0;
        status_word[0]                = (count == '0);
        status_word[1]                = (count == FULL_CNT);
        status_word[16 +: CNT_WIDTH]  = count;

        pop_rdata_next = '0;
        pop_opc_next   = 1'b0;
        if (!pop_wen_i) begin
            pop_opc_next = 1'b1;
        end else if (is_data) begin
            pop_rdata_next = mem[rd_ptr];
        end else if (is_status) begin
            pop_rdata_next = status_word;
        end else begin
            pop_opc_next = 1'b1;
        end

        count_next = count;
        case ({push_write, pop_data})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array has no reset; count and pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push_write) begin
            mem[wr_ptr] <= push_wdata_i;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            nonempty_o     <= 1'b0;
            push_r_valid_o <= 1'b0;
            push_r_opc_o   <= 1'b0;
            push_r_id_o    <= '0;
            pop_r_valid_o  <= 1'b0;
            pop_r_opc_o    <= 1'b0;
            pop_r_id_o     <= '0;
            pop_r_rdata_o  <= '0;
        end else begin
            count          <= count_next;
            nonempty_o     <= (count_next != '0);
            push_r_valid_o <= push_gnt_o;
            pop_r_valid_o  <= pop_gnt_o;
            if (push_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_data) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_gnt_o) begin
                push_r_opc_o <= push_wen_i;
                push_r_id_o  <= push_id_i;
            end
            if (pop_gnt_o) begin
                pop_r_opc_o   <= pop_opc_next;
                pop_r_id_o    <= pop_id_i;
                pop_r_rdata_o <= pop_rdata_next;
            end
        end
    end

endmodule

// File: tb/tb_inter_core_fifo.sv
// Self-checking bench for inter_core_fifo: directed steps plus random traffic against a queue-based model.
module tb_inter_core_fifo;

    localparam int DEPTH = 32;
    localparam int DW    = 32;
    localparam int IDW   = 5;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           push_req_i;
    logic           push_wen_i;
    logic [DW-1:0]  push_wdata_i;
    logic [IDW-1:0] push_id_i;
    logic           push_gnt_o;
    logic           push_r_valid_o;
    logic           push_r_opc_o;
    logic [IDW-1:0] push_r_id_o;
    logic           pop_req_i;
    logic [3:0]     pop_add_i;
    logic           pop_wen_i;
    logic [IDW-1:0] pop_id_i;
    logic           pop_gnt_o;
    logic           pop_r_valid_o;
    logic           pop_r_opc_o;
    logic [IDW-1:0] pop_r_id_o;
    logic [DW-1:0]  pop_r_rdata_o;
    logic           nonempty_o;

    inter_core_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_req_i(push_req_i), .push_wen_i(push_wen_i), .push_wdata_i(push_wdata_i),
        .push_id_i(push_id_i), .push_gnt_o(push_gnt_o), .push_r_valid_o(push_r_valid_o),
        .push_r_opc_o(push_r_opc_o), .push_r_id_o(push_r_id_o),
        .pop_req_i(pop_req_i), .pop_add_i(pop_add_i), .pop_wen_i(pop_wen_i),
        .pop_id_i(pop_id_i), .pop_gnt_o(pop_gnt_o), .pop_r_valid_o(pop_r_valid_o),
        .pop_r_opc_o(pop_r_opc_o), .pop_r_id_o(pop_r_id_o), .pop_r_rdata_o(pop_r_rdata_o),
        .nonempty_o(nonempty_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] model_q[$];
    logic last_push_gnt;
    logic last_pop_gnt;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_status(input int n);
        int v;
        v = n * 65536;
        if (n == 0)     v = v + 1;
        if (n == DEPTH) v = v + 2;
        return DW'(v);
    endfunction

    // One clock of traffic: drive, check grants mid-cycle, check responses after the edge.
    task automatic do_cycle(input logic preq, input logic pwen, input logic [DW-1:0] pdata,
                            input logic [IDW-1:0] pid, input logic qreq, input logic [3:0] qadd,
                            input logic qwen, input logic [IDW-1:0] qid, input logic rst);
        logic          eg_push, eg_pop, e_popc;
        logic [DW-1:0] e_rdata;
        int            n;
        rst_i = rst; push_req_i = preq; push_wen_i = pwen; push_wdata_i = pdata; push_id_i = pid;
        pop_req_i = qreq; pop_add_i = qadd; pop_wen_i = qwen; pop_id_i = qid;
        n = model_q.size();
        eg_push = preq && (pwen || n != DEPTH);
        eg_pop  = qreq && (!qwen || qadd != 4'h0 || n != 0);
        e_popc  = !qwen || (qadd != 4'h0 && qadd != 4'h4);
        e_rdata = '0;
        if (qwen && qadd == 4'h0 && n != 0) e_rdata = model_q[0];
        if (qwen && qadd == 4'h4)           e_rdata = model_status(n);
        @(negedge clk_i);
        check("push_gnt", DW'(push_gnt_o), DW'(eg_push));
        check("pop_gnt",  DW'(pop_gnt_o),  DW'(eg_pop));
        last_push_gnt = push_gnt_o;
        last_pop_gnt  = pop_gnt_o;
        @(posedge clk_i);
        #1;
        if (rst) begin
            model_q.delete();
            check("rst_push_valid", DW'(push_r_valid_o), '0);
            check("rst_push_opc",   DW'(push_r_opc_o),   '0);
            check("rst_push_id",    DW'(push_r_id_o),    '0);
            check("rst_pop_valid",  DW'(pop_r_valid_o),  '0);
            check("rst_pop_opc",    DW'(pop_r_opc_o),    '0);
            check("rst_pop_id",     DW'(pop_r_id_o),     '0);
            check("rst_rdata",      pop_r_rdata_o,       '0);
        end else begin
            if (eg_pop && qwen && qadd == 4'h0) void'(model_q.pop_front());
            if (eg_push && !pwen) model_q.push_back(pdata);
            check("push_r_valid", DW'(push_r_valid_o), DW'(eg_push));
            if (eg_push) begin
                check("push_r_id",  DW'(push_r_id_o),  DW'(pid));
                check("push_r_opc", DW'(push_r_opc_o), DW'(pwen));
            end
            check("pop_r_valid", DW'(pop_r_valid_o), DW'(eg_pop));
            if (eg_pop) begin
                check("pop_r_id",  DW'(pop_r_id_o),  DW'(qid));
                check("pop_r_opc", DW'(pop_r_opc_o), DW'(e_popc));
                if (qwen) check("pop_rdata", pop_r_rdata_o, e_rdata);
            end
        end
        check("nonempty", DW'(nonempty_o), DW'(model_q.size() != 0));
    endtask

    task automatic idle();
        do_cycle(0, 0, '0, '0, 0, 4'h0, 1, '0, 0);
    endtask
    task automatic push(input logic [DW-1:0] d, input logic [IDW-1:0] id);
        do_cycle(1, 0, d, id, 0, 4'h0, 1, '0, 0);
    endtask
    task automatic pop_data(input logic [IDW-1:0] id);
        do_cycle(0, 0, '0, '0, 1, 4'h0, 1, id, 0);
    endtask
    task automatic read_status();
        do_cycle(0, 0, '0, '0, 1, 4'h4, 1, IDW'($urandom), 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        do_cycle(0, 0, '0, '0, 0, 4'h0, 1, '0, 1);
        do_cycle(1, 0, 32'h1234_5678, 5'd1, 1, 4'h4, 1, 5'd2, 1);
        idle();

        // Single push and status read
        push(32'hA5A5_0001, 5'd3);
        check("first_push_gnt", DW'(last_push_gnt), 32'd1);
        check("first_push_id",  DW'(push_r_id_o),   32'd3);
        check("first_nonempty", DW'(nonempty_o),    32'd1);
        read_status();
        check("status_one", pop_r_rdata_o, 32'h0001_0000);
        pop_data(5'd4);
        check("first_pop_data", pop_r_rdata_o, 32'hA5A5_0001);

        // Fill, overflow back-pressure, pop-release, drain
        for (int i = 0; i < DEPTH; i++) push(DW'(i), IDW'(i));
        read_status();
        check("status_full", pop_r_rdata_o, 32'h0020_0002);
        push(32'h0000_0020, 5'd9);
        check("full_push_held", DW'(last_push_gnt), 32'd0);
        do_cycle(1, 0, 32'h0000_0020, 5'd9, 1, 4'h0, 1, 5'd10, 0);
        check("full_pop_no_bypass", DW'(last_push_gnt), 32'd0);
        check("full_pop_head", pop_r_rdata_o, 32'd0);
        push(32'h0000_0020, 5'd9);
        check("held_push_gnt", DW'(last_push_gnt), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            pop_data(IDW'(i));
            check("drain_order", pop_r_rdata_o, DW'(i));
        end
        read_status();
        check("status_empty", pop_r_rdata_o, 32'h0000_0001);

        // Pop on empty stalls; no fall-through with a same-cycle push
        pop_data(5'd7);
        check("empty_pop_gnt", DW'(last_pop_gnt), 32'd0);
        do_cycle(1, 0, 32'hDEAD_BEEF, 5'd8, 1, 4'h0, 1, 5'd7, 0);
        check("no_fallthrough", DW'(last_pop_gnt), 32'd0);
        pop_data(5'd7);
        check("stalled_pop_data", pop_r_rdata_o, 32'hDEAD_BEEF);
        check("stalled_pop_id",   DW'(pop_r_id_o), 32'd7);

        // Steady state at count=5 with simultaneous push and pop, wrapping pointers
        for (int i = 0; i < 5; i++) push($urandom, IDW'($urandom));
        for (int i = 0; i < 40; i++)
            do_cycle(1, 0, $urandom, IDW'($urandom), 1, 4'h0, 1, IDW'($urandom), 0);
        read_status();
        check("status_steady", pop_r_rdata_o, 32'h0005_0000);

        // Illegal accesses
        do_cycle(0, 0, '0, '0, 1, 4'h0, 0, 5'd11, 0);
        check("pop_write_opc", DW'(pop_r_opc_o), 32'd1);
        do_cycle(1, 1, 32'hFFFF_FFFF, 5'd12, 0, 4'h0, 1, '0, 0);
        check("push_read_opc", DW'(push_r_opc_o), 32'd1);
        do_cycle(0, 0, '0, '0, 1, 4'h8, 1, 5'd13, 0);
        check("unmapped_rdata", pop_r_rdata_o, 32'd0);
        read_status();
        check("status_after_err", pop_r_rdata_o, 32'h0005_0000);

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 32'h4;
                1:       d = 32'h8;
                default: d = 32'h0;
            endcase
            do_cycle(($urandom % 4) != 0, ($urandom % 10) == 0, $urandom, IDW'($urandom),
                     ($urandom % 3) != 0, d[3:0], ($urandom % 10) != 0, IDW'($urandom), 0);
        end

        // Reset while a pop is granted at count=10
        while (model_q.size() > 0) pop_data(IDW'($urandom));
        for (int i = 0; i < 10; i++) push($urandom, IDW'($urandom));
        do_cycle(0, 0, '0, '0, 1, 4'h0, 1, 5'd14, 1);
        check("rst_pop_granted", DW'(last_pop_gnt), 32'd1);
        check("rst_nonempty", DW'(nonempty_o), 32'd0);
        read_status();
        check("status_after_rst", pop_r_rdata_o, 32'h0000_0001);
        pop_data(5'd15);
        check("empty_after_rst", DW'(last_pop_gnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
